// File: rtl/ip_msxbus_initiator.sv
// MSX/Z80 bus-cycle initiator: T1, T2, TW*, T3 with each T-state lasting CLK_DIV clk cycles.
// Optional wait timeout (adds output timeout) is enabled by defining MSXBUS_INITIATOR_TIMEOUT_EN.
module ip_msxbus_initiator #(
    parameter int unsigned CLK_DIV = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic        is_io,
    input  logic [15:0] address,
    input  logic [7:0]  wdata,
    output logic        busy,
    output logic        ack,
    output logic [7:0]  rdata,
    output logic [15:0] adr,
    output logic [7:0]  o_data,
    input  logic [7:0]  i_data,
    output logic        is_output,
    output logic        n_sltsl,
    output logic        n_mereq,
    output logic        n_ioreq,
    output logic        n_rd,
    output logic        n_wr,
    input  logic        n_wait
`ifdef MSXBUS_INITIATOR_TIMEOUT_EN
    ,
    output logic        timeout
`endif
);
    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] T_LAST = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, T1, T2, TW, T3} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_q, io_q;
    logic [1:0]    sync_q;
    logic          wait_s, t_end, accept, cur_wr, cur_io, force_t3, strb;
    logic          busy_d, ack_d, is_output_d;
    logic          n_sltsl_d, n_mereq_d, n_ioreq_d, n_rd_d, n_wr_d;
    logic [7:0]    rd_value;

    assign wait_s = sync_q[1];
    assign t_end  = (cnt_q == T_LAST);
    assign accept = (state_q == IDLE) && req;
    // Attributes of the cycle being entered: fresh inputs on acceptance, latched copies otherwise.
    assign cur_wr = accept ? wr : wr_q;
    assign cur_io = accept ? is_io : io_q;

`ifdef MSXBUS_INITIATOR_TIMEOUT_EN
    logic [9:0] tw_cnt_q, tw_cnt_d;
    logic       to_q, to_d;

    assign force_t3 = (state_q == TW) && t_end && !wait_s && (tw_cnt_q == 10'd1023);
    assign rd_value = to_d ? 8'hFF : i_data;

    // Count completed consecutive wait states; remember a forced exit until IDLE.
    always_comb begin
        tw_cnt_d = tw_cnt_q;
        to_d     = to_q;
        if (state_d != TW)                 tw_cnt_d = '0;
        else if ((state_q == TW) && t_end) tw_cnt_d = tw_cnt_q + 10'd1;
        if (state_q == IDLE) to_d = 1'b0;
        else if (force_t3)   to_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tw_cnt_q <= '0;
            to_q     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            tw_cnt_q <= tw_cnt_d;
            to_q     <= to_d;
            timeout  <= ack_d && to_d;
        end
    end
`else
    assign force_t3 = 1'b0;
    assign rd_value = i_data;
`endif

    // State register and T-state counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sync_q  <= 2'b11;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sync_q  <= {sync_q[0], n_wait};
        end
    end

    // Next state: I/O cycles always take one TW before the wait sample applies.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
            if (req) state_d = T1;
        end else if (t_end) begin
            cnt_d = '0;
            unique case (state_q)
                T1:      state_d = T2;
                T2:      state_d = (io_q || !wait_s) ? TW : T3;
                TW:      state_d = (wait_s || force_t3) ? T3 : TW;
                T3:      state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Output decode from the next state so every output is a plain register.
    always_comb begin
        strb        = (state_d == T2) || (state_d == TW) || (state_d == T3);
        busy_d      = (state_d != IDLE);
        ack_d       = (state_d == T3) && (cnt_d == T_LAST);
        is_output_d = busy_d && cur_wr;
        n_rd_d      = !(strb && !cur_wr);
        n_wr_d      = !(strb && cur_wr);
        n_ioreq_d   = !(strb && cur_io);
        n_mereq_d   = !(strb && !cur_io);
        n_sltsl_d   = !(strb && !cur_io);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy      <= 1'b0;
            ack       <= 1'b0;
            rdata     <= 8'hFF;
            adr       <= 16'h0000;
            o_data    <= 8'h00;
            is_output <= 1'b0;
            n_sltsl   <= 1'b1;
            n_mereq   <= 1'b1;
            n_ioreq   <= 1'b1;
            n_rd      <= 1'b1;
            n_wr      <= 1'b1;
            wr_q      <= 1'b0;
            io_q      <= 1'b0;
        end else begin
            busy      <= busy_d;
            ack       <= ack_d;
            is_output <= is_output_d;
            n_sltsl   <= n_sltsl_d;
            n_mereq   <= n_mereq_d;
            n_ioreq   <= n_ioreq_d;
            n_rd      <= n_rd_d;
            n_wr      <= n_wr_d;
            if (accept) begin
                adr    <= address;
                o_data <= wdata;
                wr_q   <= wr;
                io_q   <= is_io;
            end
            if (ack_d && !cur_wr) rdata <= rd_value;
        end
    end
endmodule
